// File: rtl/heater_bank_ctrl.sv
// Heater bank controller: ramps channel enables on in groups with a settle gap,
// drops them immediately, and tracks sticky per-channel errors with event counters.
module heater_bank_ctrl #(
    parameter int Nchan      = 32,
    parameter int Ngroup     = 4,
    parameter int RampCycles = 1024,
    parameter int CntWidth   = 8,
    localparam int SelW      = (Nchan > 1) ? $clog2(Nchan) : 1,
    localparam int TW        = $clog2(RampCycles)
) (
    input  logic                clk,
    input  logic                aresetn,
    input  logic [Nchan-1:0]    enable_req,
    input  logic [Nchan-1:0]    err_clear,
    input  logic                auto_off,
    input  logic [Nchan-1:0]    heater_error,
    output logic [Nchan-1:0]    heater_enable,
    output logic [Nchan-1:0]    heater_err_clear,
    output logic [Nchan-1:0]    err_sticky,
    input  logic [SelW-1:0]     err_count_sel,
    output logic [CntWidth-1:0] err_count,
    output logic                busy,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {IDLE = 2'd0, STEP = 2'd1, SETTLE = 2'd2} state_t;

    state_t                        st, st_next;
    logic [TW-1:0]                 timer, timer_next;
    logic [Nchan-1:0]              target, pending, step_set;
    logic [Nchan-1:0]              err_d, err_rise;
    logic [Nchan-1:0][CntWidth-1:0] cnt;
    logic [CntWidth-1:0]           cnt_rd;
    int                            taken;

    assign target   = enable_req & ~(auto_off ? err_sticky : '0);
    assign pending  = target & ~heater_enable;
    assign err_rise = heater_error & ~err_d;
    assign state    = st;

    always_comb begin
        st_next    = st;
        timer_next = timer;
        step_set   = '0;
        taken      = 0;
        case (st)
            IDLE: if (|pending) st_next = STEP;
            STEP: begin
                // lowest-index pending channels first, at most Ngroup per step
                for (int i = 0; i < Nchan; i++) begin
                    if (pending[i] && taken < Ngroup) begin
                        step_set[i] = 1'b1;
                        taken       = taken + 1;
                    end
                end
                timer_next = TW'(RampCycles - 1);
                st_next    = SETTLE;
            end
            SETTLE: begin
                if (timer == '0) st_next = (|pending) ? STEP : IDLE;
                else             timer_next = timer - 1'b1;
            end
            default: st_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            st               <= IDLE;
            busy             <= 1'b0;
            timer            <= '0;
            heater_enable    <= '0;
            heater_err_clear <= '0;
            err_d            <= '0;
            err_sticky       <= '0;
            err_count        <= '0;
        end else begin
            st               <= st_next;
            busy             <= (st_next != IDLE);
            timer            <= timer_next;
            heater_enable    <= (heater_enable & target) | step_set;
            heater_err_clear <= err_clear;
            err_d            <= heater_error;
            // a live error always wins over a clear request
            err_sticky       <= heater_error | (err_sticky & ~err_clear);
            err_count        <= cnt_rd;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            cnt <= '0;
        end else begin
            for (int i = 0; i < Nchan; i++) begin
                if (err_clear[i])
                    cnt[i] <= err_rise[i] ? CntWidth'(1) : '0;
                else if (err_rise[i] && cnt[i] != '1)
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // out-of-range select matches no channel and reads zero
    always_comb begin
        cnt_rd = '0;
        for (int i = 0; i < Nchan; i++)
            if (err_count_sel == SelW'(i)) cnt_rd = cnt[i];
    end

endmodule

// File: tb/tb_heater_bank_ctrl.sv
// Directed bench for heater_bank_ctrl: ramp table, turn-off, auto_off, counter
// saturation, async reset mid-ramp and out-of-range readback.
module tb_heater_bank_ctrl;

    logic       clk = 1'b0;
    logic       aresetn;
    logic [7:0] enable_req, err_clear, heater_error;
    logic       auto_off;
    logic [7:0] heater_enable, heater_err_clear, err_sticky;
    logic [2:0] err_count_sel;
    logic [7:0] err_count;
    logic       busy;
    logic [1:0] state;

    logic [5:0] err_b, en_b, clr_b, he_b, hec_b, st_b;
    logic [2:0] sel_b;
    logic [7:0] cnt_b;
    logic       busy_b;
    logic [1:0] state_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    heater_bank_ctrl #(.Nchan(8), .Ngroup(2), .RampCycles(4), .CntWidth(8)) dut (
        .clk(clk), .aresetn(aresetn), .enable_req(enable_req), .err_clear(err_clear),
        .auto_off(auto_off), .heater_error(heater_error), .heater_enable(heater_enable),
        .heater_err_clear(heater_err_clear), .err_sticky(err_sticky),
        .err_count_sel(err_count_sel), .err_count(err_count), .busy(busy), .state(state));

    heater_bank_ctrl #(.Nchan(6), .Ngroup(2), .RampCycles(4), .CntWidth(8)) dut_b (
        .clk(clk), .aresetn(aresetn), .enable_req(en_b), .err_clear(clr_b),
        .auto_off(1'b0), .heater_error(err_b), .heater_enable(he_b),
        .heater_err_clear(hec_b), .err_sticky(st_b),
        .err_count_sel(sel_b), .err_count(cnt_b), .busy(busy_b), .state(state_b));

    typedef struct {
        logic [7:0] he;
        logic [1:0] st;
        logic       bsy;
    } vec_t;

    vec_t ramp[1:21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        #12;
        @(negedge clk);
        aresetn = 1'b1;
    endtask

    initial begin
        // expected state after each edge following enable_req 00 -> FF
        ramp[1]  = '{8'h00, 2'd1, 1'b1}; ramp[2]  = '{8'h03, 2'd2, 1'b1};
        ramp[3]  = '{8'h03, 2'd2, 1'b1}; ramp[4]  = '{8'h03, 2'd2, 1'b1};
        ramp[5]  = '{8'h03, 2'd2, 1'b1}; ramp[6]  = '{8'h03, 2'd1, 1'b1};
        ramp[7]  = '{8'h0F, 2'd2, 1'b1}; ramp[8]  = '{8'h0F, 2'd2, 1'b1};
        ramp[9]  = '{8'h0F, 2'd2, 1'b1}; ramp[10] = '{8'h0F, 2'd2, 1'b1};
        ramp[11] = '{8'h0F, 2'd1, 1'b1}; ramp[12] = '{8'h3F, 2'd2, 1'b1};
        ramp[13] = '{8'h3F, 2'd2, 1'b1}; ramp[14] = '{8'h3F, 2'd2, 1'b1};
        ramp[15] = '{8'h3F, 2'd2, 1'b1}; ramp[16] = '{8'h3F, 2'd1, 1'b1};
        ramp[17] = '{8'hFF, 2'd2, 1'b1}; ramp[18] = '{8'hFF, 2'd2, 1'b1};
        ramp[19] = '{8'hFF, 2'd2, 1'b1}; ramp[20] = '{8'hFF, 2'd2, 1'b1};
        ramp[21] = '{8'hFF, 2'd0, 1'b0};

        enable_req = '0; err_clear = '0; heater_error = '0; auto_off = 1'b0;
        err_count_sel = '0;
        err_b = '0; en_b = '0; clr_b = '0; sel_b = '0;
        do_reset();

        check("reset_enable", heater_enable, 8'h00);
        check("reset_state", {busy, state}, 3'b000);

        // full ramp from the table
        enable_req = 8'hFF;
        for (int e = 1; e <= 21; e++) begin
            step();
            check($sformatf("ramp_he_e%0d", e), heater_enable, ramp[e].he);
            check($sformatf("ramp_st_e%0d", e), {ramp[e].bsy == busy, state}, {1'b1, ramp[e].st});
        end

        // turn-off during SETTLE
        do_reset();
        enable_req = 8'hFF;
        step(8);
        check("settle_pre", heater_enable, 8'h0F);
        enable_req = 8'hFD;
        step();
        check("drop_immediate", heater_enable, 8'h0D);
        step(2);
        check("timer_kept", state, 2'd1);
        step();
        check("ramp_cont_e12", heater_enable, 8'h3D);
        step(5);
        check("ramp_cont_e17", heater_enable, 8'hFD);
        step(4);
        check("ramp_cont_idle", {busy, state}, 3'b000);

        // auto_off on channel 5
        enable_req = 8'hFF;
        step(10);
        check("all_on", heater_enable, 8'hFF);
        auto_off = 1'b1;
        err_count_sel = 3'd5;
        heater_error = 8'h20;
        step();
        check("sticky_set", err_sticky, 8'h20);
        check("still_on_e1", heater_enable, 8'hFF);
        step();
        check("auto_off_drop", heater_enable, 8'hDF);
        check("count_ch5", err_count, 8'd1);
        step();
        heater_error = 8'h00;
        step();
        check("sticky_holds", err_sticky, 8'h20);
        err_clear = 8'h20;
        step();
        check("sticky_cleared", err_sticky, 8'h00);
        check("err_clear_fwd", heater_err_clear, 8'h20);
        err_clear = 8'h00;
        step();
        check("reenter_step", {heater_enable, state}, {8'hDF, 2'd1});
        check("count_cleared", err_count, 8'd0);
        step();
        check("ch5_back", heater_enable, 8'hFF);

        // saturation with auto_off off: enables untouched
        auto_off = 1'b0;
        err_count_sel = 3'd2;
        for (int i = 0; i < 300; i++) begin
            heater_error = 8'h04; step();
            heater_error = 8'h00; step();
        end
        check("count_sat", err_count, 8'd255);
        check("no_auto_off", heater_enable, 8'hFF);
        check("sticky_ch2", err_sticky, 8'h04);
        err_clear = 8'h04;
        step();
        check("clear_ch2", err_sticky, 8'h00);
        step();
        check("clear_cnt2", err_count, 8'd0);
        heater_error = 8'h04;
        step();
        check("set_wins", err_sticky, 8'h04);
        err_clear = 8'h00;
        heater_error = 8'h00;
        step();
        check("clear_and_rise", err_count, 8'd1);

        // async reset mid-ramp
        enable_req = 8'h00;
        step(2);
        check("all_off", heater_enable, 8'h00);
        enable_req = 8'hFF;
        step(8);
        check("mid_ramp", heater_enable, 8'h0F);
        #2 aresetn = 1'b0;
        #1;
        check("arst_enable", heater_enable, 8'h00);
        check("arst_sticky", err_sticky, 8'h00);
        check("arst_count", err_count, 8'h00);
        check("arst_state", {busy, state, heater_err_clear}, 11'd0);
        @(negedge clk);
        aresetn = 1'b1;
        step();
        check("restart_step", {heater_enable, state}, {8'h00, 2'd1});
        step();
        check("restart_group", heater_enable, 8'h03);

        // out-of-range readback on a 6-channel instance
        err_b = 6'h3F;
        step();
        err_b = 6'h00;
        sel_b = 3'd5;
        step();
        check("b_count5", cnt_b, 8'd1);
        sel_b = 3'd7;
        step();
        check("b_sel7", cnt_b, 8'd0);
        sel_b = 3'd6;
        step();
        check("b_sel6", cnt_b, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
